// File: rtl/rojo_updt_handshake_pkg.sv
// Shared constants for the Rojobot update handshake.
// State encodings and default synchronizer/timeout settings.
package rojo_updt_handshake_pkg;

  typedef enum logic [1:0] {
    ROJO_HS_IDLE    = 2'd0,
    ROJO_HS_PENDING = 2'd1,
    ROJO_HS_ACKED   = 2'd2
  } hs_state_e;

  localparam int unsigned ROJO_SYNC_STAGES_DEF = 2;
  localparam int unsigned ROJO_TIMEOUT_CYC_DEF = 1_000_000;

endpackage

// File: rtl/rojo_updt_handshake_sync_edge.sv
// Strobe synchronizer plus registered rising-edge detector.
// Data rides an equal-length delay line so it stays aligned with the edge.
module rojo_sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          strb_i,
  input  logic [DW-1:0] data_i,
  output logic          edge_o,
  output logic [DW-1:0] data_o
);

  logic          sync_out;
  logic [DW-1:0] data_dly;
  logic          sync_d_q;
  logic          edge_q;
  logic [DW-1:0] data_q;

  generate
    if (STAGES == 0) begin : g_bypass
      assign sync_out = strb_i;
      assign data_dly = data_i;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      logic [DW-1:0]     dly_q [STAGES];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= '0;
          for (int i = 0; i < int'(STAGES); i++)
            dly_q[i] <= '0;
        end else begin
          sync_q[0] <= strb_i;
          dly_q[0]  <= data_i;
          for (int i = 1; i < int'(STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
            dly_q[i]  <= dly_q[i-1];
          end
        end
      end

      assign sync_out = sync_q[STAGES-1];
      assign data_dly = dly_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_d_q <= 1'b0;
      edge_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      sync_d_q <= sync_out;
      edge_q   <= sync_out & ~sync_d_q;
      data_q   <= data_dly;
    end
  end

  assign edge_o = edge_q;
  assign data_o = data_q;

endmodule

// File: rtl/rojo_updt_handshake.sv
// Rojobot update -> mfp_ahb four-phase handshake with one-deep shadow.
// Define ROJO_UPDT_TIMEOUT_EN to add a PENDING timeout and timeout_cnt.
import rojo_updt_handshake_pkg::*;

module rojo_updt_handshake #(
  parameter int unsigned SYNC_STAGES = ROJO_SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = 8
`ifdef ROJO_UPDT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = ROJO_TIMEOUT_CYC_DEF
`endif
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             bot_upd_sysregs,
  input  logic [31:0]      bot_info,
  input  logic             IO_INT_ACK,
  output logic             IO_BotUpdt_Sync,
  output logic [31:0]      IO_BotInfo,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             shadow_valid
`ifdef ROJO_UPDT_TIMEOUT_EN
  , output logic [7:0]     timeout_cnt
`endif
);

  logic        upd_edge;
  logic [31:0] upd_data;

  hs_state_e        state_q;
  logic             sync_q;
  logic [31:0]      info_q;
  logic [31:0]      shadow_q;
  logic             sv_q;
  logic [CNT_W-1:0] ovr_q;
  logic             to_hit;
  logic             to_shadow;

  rojo_sync_edge #(
    .STAGES (SYNC_STAGES),
    .DW     (32)
  ) u_sync_edge (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .strb_i (bot_upd_sysregs),
    .data_i (bot_info),
    .edge_o (upd_edge),
    .data_o (upd_data)
  );

`ifdef ROJO_UPDT_TIMEOUT_EN
  logic [31:0] to_q;
  logic [7:0]  tcnt_q;

  assign to_hit = (to_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_q   <= '0;
      tcnt_q <= '0;
    end else begin
      if (state_q != ROJO_HS_PENDING)
        to_q <= '0;
      else
        to_q <= to_q + 32'd1;
      if (state_q == ROJO_HS_PENDING && !IO_INT_ACK
          && to_hit && tcnt_q != 8'hFF)
        tcnt_q <= tcnt_q + 8'd1;
    end
  end

  assign timeout_cnt = tcnt_q;
`else
  assign to_hit = 1'b0;
`endif

  // Edges land in the shadow unless ACKED is about to release with it empty.
  assign to_shadow = upd_edge & (state_q == ROJO_HS_PENDING
    | (state_q == ROJO_HS_ACKED & (IO_INT_ACK | sv_q)));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ROJO_HS_IDLE;
      sync_q   <= 1'b0;
      info_q   <= '0;
      shadow_q <= '0;
      sv_q     <= 1'b0;
      ovr_q    <= '0;
    end else begin
      if (to_shadow) begin
        shadow_q <= upd_data;
        sv_q     <= 1'b1;
        if (sv_q && ovr_q != '1)
          ovr_q <= ovr_q + CNT_W'(1);
      end
      unique case (state_q)
        ROJO_HS_IDLE: begin
          if (upd_edge) begin
            info_q  <= upd_data;
            sync_q  <= 1'b1;
            state_q <= ROJO_HS_PENDING;
          end
        end
        ROJO_HS_PENDING: begin
          if (IO_INT_ACK || to_hit) begin
            sync_q  <= 1'b0;
            state_q <= ROJO_HS_ACKED;
          end
        end
        ROJO_HS_ACKED: begin
          if (!IO_INT_ACK) begin
            if (sv_q) begin
              info_q  <= shadow_q;
              sv_q    <= to_shadow;
              sync_q  <= 1'b1;
              state_q <= ROJO_HS_PENDING;
            end else if (upd_edge) begin
              info_q  <= upd_data;
              sync_q  <= 1'b1;
              state_q <= ROJO_HS_PENDING;
            end else begin
              state_q <= ROJO_HS_IDLE;
            end
          end
        end
        default: state_q <= ROJO_HS_IDLE;
      endcase
    end
  end

  assign IO_BotUpdt_Sync = sync_q;
  assign IO_BotInfo      = info_q;
  assign overrun_cnt     = ovr_q;
  assign shadow_valid    = sv_q;

endmodule

// File: tb/tb_rojo_updt_handshake.sv
// Directed bench for rojo_updt_handshake (SYNC_STAGES=2, CNT_W=8).
// With ROJO_UPDT_TIMEOUT_EN defined, TIMEOUT_CYC=100 is also exercised.
module tb_rojo_updt_handshake;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strb;
  logic [31:0] info;
  logic        ack;
  logic        sync;
  logic [31:0] bi;
  logic [7:0]  ovr;
  logic        sv;
`ifdef ROJO_UPDT_TIMEOUT_EN
  logic [7:0]  tcnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rojo_updt_handshake #(
    .SYNC_STAGES (2),
    .CNT_W       (8)
`ifdef ROJO_UPDT_TIMEOUT_EN
    , .TIMEOUT_CYC (100)
`endif
  ) dut (
    .HCLK            (clk),
    .HRESETn         (rst_n),
    .bot_upd_sysregs (strb),
    .bot_info        (info),
    .IO_INT_ACK      (ack),
    .IO_BotUpdt_Sync (sync),
    .IO_BotInfo      (bi),
    .overrun_cnt     (ovr),
    .shadow_valid    (sv)
`ifdef ROJO_UPDT_TIMEOUT_EN
    , .timeout_cnt   (tcnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe, then idle long enough for the update to land.
  task automatic pulse(input logic [31:0] w);
    strb = 1'b1;
    info = w;
    tick();
    strb = 1'b0;
    info = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
  endtask

  task automatic handshake();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    int rises;
    int highs;
    logic prev;
    rst_n = 1'b0;
    strb  = 1'b0;
    info  = '0;
    ack   = 1'b0;
    tick();
    tick();
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_info", bi, 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_sv", 32'(sv), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single update: Sync appears on the 4th edge after the strobe.
    strb = 1'b1;
    info = 32'h1234_5678;
    tick();
    strb = 1'b0;
    info = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("lat_early", 32'(sync), 32'd0);
    tick();
    chk("lat_sync", 32'(sync), 32'd1);
    chk("lat_info", bi, 32'h1234_5678);
    ack = 1'b1;
    tick();
    chk("ack_sync", 32'(sync), 32'd0);
    ack = 1'b0;
    tick();
    chk("idle_sync", 32'(sync), 32'd0);
    chk("idle_ovr", 32'(ovr), 32'd0);
    chk("idle_sv", 32'(sv), 32'd0);

    // Long strobe yields exactly one update.
    rises = 0;
    prev  = sync;
    strb  = 1'b1;
    info  = 32'h5050_5050;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) strb = 1'b0;
      tick();
      if (sync && !prev) rises++;
      prev = sync;
    end
    chk("hold_rises", 32'(rises), 32'd1);
    chk("hold_sv", 32'(sv), 32'd0);
    chk("hold_info", bi, 32'h5050_5050);
    handshake();

    // Two updates during PENDING: latest wins, one overrun.
    pulse(32'h1111_2222);
    pulse(32'hAAAA_0001);
    pulse(32'hAAAA_0002);
    chk("pend_info", bi, 32'h1111_2222);
    chk("pend_sv", 32'(sv), 32'd1);
    chk("pend_ovr", 32'(ovr), 32'd1);
    ack = 1'b1;
    tick();
    chk("acked_sync", 32'(sync), 32'd0);
    chk("acked_info", bi, 32'h1111_2222);
    ack = 1'b0;
    tick();
    chk("reload_sync", 32'(sync), 32'd1);
    chk("reload_info", bi, 32'hAAAA_0002);
    chk("reload_sv", 32'(sv), 32'd0);
    handshake();

    // Overrun counter saturates without wrapping.
    for (int i = 0; i < 300; i++) pulse(i);
    chk("sat_ovr", 32'(ovr), 32'hFF);
    chk("sat_sync", 32'(sync), 32'd1);
    chk("sat_sv", 32'(sv), 32'd1);
    handshake();
    handshake();
    chk("sat_idle", 32'(sync), 32'd0);
    chk("sat_hold", 32'(ovr), 32'hFF);

    // Ack held high in IDLE: update passes straight to ACKED.
    ack = 1'b1;
    tick();
    tick();
    chk("ackidle_sync", 32'(sync), 32'd0);
    highs = 0;
    strb  = 1'b1;
    info  = 32'h7777_8888;
    for (int i = 0; i < 8; i++) begin
      tick();
      strb = 1'b0;
      if (sync) highs++;
    end
    chk("ackidle_highs", 32'(highs), 32'd1);
    ack = 1'b0;
    tick();
    chk("ackidle_drop", 32'(sync), 32'd0);
    chk("ackidle_info", bi, 32'h7777_8888);

    // Asynchronous reset mid-PENDING with shadow occupied.
    pulse(32'h0000_0001);
    pulse(32'h0000_0002);
    chk("pre_rst_sv", 32'(sv), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sync", 32'(sync), 32'd0);
    chk("arst_info", bi, 32'd0);
    chk("arst_ovr", 32'(ovr), 32'd0);
    chk("arst_sv", 32'(sv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_sync", 32'(sync), 32'd0);
    chk("post_rst_sv", 32'(sv), 32'd0);

`ifdef ROJO_UPDT_TIMEOUT_EN
    begin
      int n;
      strb = 1'b1;
      info = 32'hC0DE_0001;
      tick();
      strb = 1'b0;
      n = 0;
      while (!sync && n < 10) begin
        tick();
        n++;
      end
      chk("to_enter", 32'(sync), 32'd1);
      for (int i = 0; i < 99; i++) tick();
      chk("to_before", 32'(sync), 32'd1);
      tick();
      chk("to_drop", 32'(sync), 32'd0);
      chk("to_cnt", 32'(tcnt), 32'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
